life_generation_sequencer: RTL
==============================

// Module: life_generation_sequencer
// PURPOSE
// Sits directly downstream of the 1-second timer in the Game of Life datapath.
// Consumes its single-cycle tick pulse, divides it to a generation rate and supports run/pause/single-step.
// Per generation it sweeps every row of the cell array over a valid/ready handshake,
// then issues a one-cycle commit that swaps the array's double buffer.
// PARAMETERS
// ROWS           8   number of grid rows swept per generation (>=2)
// TICKS_PER_GEN  1   timer ticks per generation while running (>=1)
// GEN_W          16  width of generation counter
// PORTS
// clk         in   1                 system clock (12 MHz)
// rst         in   1                 asynchronous, active-high reset
// tick_pulse  in   1                 one-cycle pulse from 1-second timer
// run         in   1                 level: 1 = free-run, 0 = paused
// step        in   1                 one-cycle pulse: advance one generation while paused
// row_addr    out  $clog2(ROWS)      row currently offered to cell array
// row_valid   out  1                 row_addr valid, requesting row update
// row_ready   in   1                 cell array accepts row this cycle
// commit      out  1                 one-cycle pulse: all rows done, swap buffers
// gen_count   out  GEN_W             completed generations, wraps mod 2^GEN_W
// busy        out  1                 high whenever state != IDLE
// overrun     out  1                 sticky: tick arrived while busy
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; row_addr, row_valid, commit, gen_count, busy, overrun and prescaler = 0.
// - Reset mid-sweep: row_valid drops immediately; no commit is issued and gen_count is not incremented.
// - States: IDLE -> SWEEP -> COMMIT -> IDLE.
// - Trigger, IDLE only:
//   (a) run=1 and tick_pulse=1 and prescaler==TICKS_PER_GEN-1; prescaler clears.
//   (b) run=1 and tick_pulse=1 otherwise: prescaler +1, no trigger.
//   (c) run=0 and step=1.
// - step with run=1 is ignored.
// - Same-cycle tick and step produce at most one generation.
// - Prescaler clears whenever run=0.
// - Trigger in cycle N: state=SWEEP, row_valid=1 and row_addr=0 from cycle N+1.
// - SWEEP handshake: transfer occurs when row_valid&row_ready at a clock edge.
//   row_addr is held stable until transfer. row_valid never drops inside SWEEP.
// - On transfer with row_addr<ROWS-1: row_addr+1, back-to-back transfers allowed.
// - On transfer with row_addr==ROWS-1: state=COMMIT, row_valid=0.
// - COMMIT: commit=1 for exactly one cycle; gen_count increments in the same edge that leaves COMMIT.
//   Next state IDLE; row_addr returns to 0.
// - Latency with row_ready tied 1: trigger at N -> commit high in cycle N+1+ROWS -> IDLE at N+2+ROWS.
// - Tick with run=1 while busy: overrun<=1 (sticky until rst). Tick is dropped; prescaler is unchanged.
//   step while busy is ignored silently.
// - run falling mid-sweep: the sweep and commit still complete; no new trigger afterwards.
// - gen_count: (2^GEN_W)-1 + 1 -> 0; no flag.
// STRUCTURE
// - life_pkg holds:
//   * life_seq_state_t enum {IDLE, SWEEP, COMMIT}
//   * function row_width(ROWS) = $clog2(ROWS)
//   * localparam DEFAULT_ROWS
// - Sub-module life_tick_prescaler(clk, rst, clear, tick_pulse, enable, fire):
//   * counter modulo TICKS_PER_GEN
//   * fire is combinational, valid in the cycle of the qualifying tick
// - All state registers use one always_ff block sensitive to posedge clk, posedge rst.
// TESTING
// 1. Reset: assert rst mid-SWEEP at row 3 -> row_valid/commit/busy=0 same cycle, gen_count=0, state IDLE.
// 2. Free run, ROWS=8, TICKS_PER_GEN=1, row_ready=1: tick at cycle 10 -> row_valid 11..18 with row_addr 0..7,
//    commit at 19 only, gen_count=1, busy=0 at 20.
// 3. Prescale, TICKS_PER_GEN=3, run=1: ticks 1,2 -> no row_valid; tick 3 -> sweep starts.
//    run 0 then 1 -> prescaler restarts at 0.
// 4. Backpressure: row_ready low 4 cycles at row 2 -> row_addr held at 2, row_valid=1 throughout.
//    Then resumes at 3; commit still exactly once.
// 5. Step/overrun:
//    - run=0, step pulse -> one generation.
//    - step during sweep -> ignored.
//    - run=1 with tick during sweep -> overrun=1, persists, no extra commit.
// 6. Wrap: preload via 2^GEN_W generations (GEN_W=4) -> gen_count 15 -> 0 on 16th commit.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life generation sequencer.
package life_pkg;
    typedef enum logic [1:0] {IDLE, SWEEP, COMMIT} life_seq_state_t;

    localparam int DEFAULT_ROWS = 8;

    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction
endpackage

// File: rtl/life_tick_prescaler.sv
// Divides the 1-second tick down to the generation rate; fire is combinational
// in the cycle of the qualifying tick.
module life_tick_prescaler #(
    parameter int TICKS_PER_GEN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick_pulse,
    input  logic enable,
    output logic fire
);
    localparam int CW = (TICKS_PER_GEN > 1) ? $clog2(TICKS_PER_GEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_GEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign fire = enable & tick_pulse & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (enable && tick_pulse)
            cnt_d = fire ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/life_generation_sequencer.sv
// Per generation: sweep all rows over valid/ready, then pulse commit to swap
// the cell array's double buffer. Run/pause/single-step on top of the timer tick.
module life_generation_sequencer
    import life_pkg::*;
#(
    parameter int ROWS          = DEFAULT_ROWS,
    parameter int TICKS_PER_GEN = 1,
    parameter int GEN_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick_pulse,
    input  logic                         run,
    input  logic                         step,
    output logic [row_width(ROWS)-1:0]   row_addr,
    output logic                         row_valid,
    input  logic                         row_ready,
    output logic                         commit,
    output logic [GEN_W-1:0]             gen_count,
    output logic                         busy,
    output logic                         overrun
);
    localparam int RW = row_width(ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    life_seq_state_t state_q, state_d;
    logic [RW-1:0]    row_addr_q, row_addr_d;
    logic [GEN_W-1:0] gen_count_q, gen_count_d;
    logic             overrun_q, overrun_d;
    logic             idle, fire, trigger;

    assign idle = (state_q == IDLE);

    // Prescaler only advances while idle and running; pausing restarts it.
    life_tick_prescaler #(.TICKS_PER_GEN(TICKS_PER_GEN)) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .clear     (~run),
        .tick_pulse(tick_pulse),
        .enable    (idle & run),
        .fire      (fire)
    );

    assign trigger = fire | (idle & ~run & step);

    always_comb begin
        state_d     = state_q;
        row_addr_d  = row_addr_q;
        gen_count_d = gen_count_q;
        overrun_d   = overrun_q | (tick_pulse & run & ~idle);
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d    = SWEEP;
                    row_addr_d = '0;
                end
            end
            SWEEP: begin
                if (row_ready) begin
                    if (row_addr_q == LAST_ROW) state_d = COMMIT;
                    else                        row_addr_d = row_addr_q + 1'b1;
                end
            end
            COMMIT: begin
                state_d     = IDLE;
                row_addr_d  = '0;
                gen_count_d = gen_count_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_addr_q  <= '0;
            gen_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_addr_q  <= row_addr_d;
            gen_count_q <= gen_count_d;
            overrun_q   <= overrun_d;
        end
    end

    // Outputs decode straight from state so reset drops them asynchronously.
    assign row_addr  = row_addr_q;
    assign row_valid = (state_q == SWEEP);
    assign commit    = (state_q == COMMIT);
    assign busy      = ~idle;
    assign gen_count = gen_count_q;
    assign overrun   = overrun_q;
endmodule
